// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  // Width of the wait-state counter (WAIT_CYCLES range 0..15).
  localparam int unsigned WAIT_CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Wait-state counter: cleared outside an access, counts each access cycle,
// done flags the last access cycle (cnt == WAIT_CYCLES).
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [WAIT_CW-1:0] LAST = WAIT_CW'(WAIT_CYCLES);

  logic [WAIT_CW-1:0] cnt;

  // Count access cycles; clear takes priority over enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF)
// and load/store (DM). One requester is served at a time; each access lasts
// WAIT_CYCLES+1 cycles, followed by a one-cycle ack.
// Optional feature macro: ARB_RR_EN (round-robin on simultaneous requests;
// default build uses fixed priority DM over IF).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t state;
  grant_t     grant;
  grant_t     pick;
  logic       cnt_en;
  logic       cnt_clear;
  logic       cnt_done;

`ifdef ARB_RR_EN
  // Port that wins the next tie; toggles after every tie so ties alternate,
  // starting with DM after reset.
  grant_t     tie_next;
`endif

  assign cnt_en    = (state == ST_ACCESS);
  assign cnt_clear = ~cnt_en;

  arb_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .done   (cnt_done)
  );

  // Select which requester would be granted from IDLE this cycle.
  always_comb begin
    pick = GNT_IF;
`ifdef ARB_RR_EN
    if (dm_req && if_req) begin
      pick = tie_next;
    end else if (dm_req) begin
      pick = GNT_DM;
    end
`else
    if (dm_req) begin
      pick = GNT_DM;
    end
`endif
  end

  // Arbitration FSM with registered acks and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      grant    <= GNT_IF;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
`ifdef ARB_RR_EN
      tie_next <= GNT_DM;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          if (if_req || dm_req) begin
            state <= ST_ACCESS;
            grant <= pick;
`ifdef ARB_RR_EN
            if (if_req && dm_req) begin
              tie_next <= (pick == GNT_DM) ? GNT_IF : GNT_DM;
            end
`endif
          end
        end
        ST_ACCESS: begin
          if (cnt_done) begin
            state  <= ST_DONE;
            if_ack <= (grant == GNT_IF);
            dm_ack <= (grant == GNT_DM);
            if (grant == GNT_IF) begin
              if_rdata <= mem_rdata;
            end else begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
        end
      endcase
    end
  end

  // Memory strobes and address/data, driven only while an access is in progress.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ST_ACCESS) begin
      if (grant == GNT_DM) begin
        mem_addr = dm_addr;
        if (dm_we) begin
          mem_write = cnt_done;
          mem_wdata = dm_wdata;
        end else begin
          mem_read = 1'b1;
        end
      end else begin
        mem_addr = if_addr;
        mem_read = 1'b1;
      end
    end
  end

  assign if_stall = if_req & ~if_ack;

endmodule
